// File: rtl/wb_dual_master_arbiter.sv
// Two-master round-robin Wishbone arbiter; grant held for the whole cyc tenure.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_dual_master_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,

  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   req0, req1;
  logic   stb_kill;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) state_d = last_q ? ST_G0 : ST_G1;
        else if (req0)    state_d = ST_G0;
        else if (req1)    state_d = ST_G1;
      end
      ST_G0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = req1 ? ST_G1 : ST_IDLE;
        end
      end
      ST_G1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = req0 ? ST_G0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_o = {state_q == ST_G1, state_q == ST_G0};

  // Slave side follows the registered grant only, so s_ack_i never reaches s_stb_o.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (state_q)
      ST_G0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i & ~stb_kill;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      ST_G1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i & ~stb_kill;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign m0_ack_o = s_ack_i & grant_o[0];
  assign m1_ack_o = s_ack_i & grant_o[1];
  assign m0_dat_o = grant_o[0] ? s_dat_i : '0;
  assign m1_dat_o = grant_o[1] ? s_dat_i : '0;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic [1:0]  err_q, err_d;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wd_cnt_q <= '0;
      err_q    <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    err_d    = '0;
    if ((state_d != state_q) || s_ack_i) begin
      wd_cnt_d = '0;
    end else if (s_stb_o) begin
      if (wd_cnt_q == WD_LIMIT) begin
        err_d    = grant_o;
        wd_cnt_d = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + 16'd1;
      end
    end
  end

  assign stb_kill = |err_q;
  assign m0_err_o = err_q[0];
  assign m1_err_o = err_q[1];
`else
  assign stb_kill = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Self-checking bench for wb_dual_master_arbiter: vector table plus scripted transfers.
module tb_wb_dual_master_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i;
  logic [1:0]  grant_o;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  wb_dual_master_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  typedef struct packed {
    logic       c0, s0, c1, s1, ack;
    logic [1:0] g;
    logic       a0, a1, stb;
  } vec_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wr_t;

  localparam int unsigned NV = 17;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;

  vec_t        tbl [NV];
  wr_t         wr_q [$];
  logic [31:0] rd_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic c0, s0, c1, s1, ack, input logic [1:0] g,
                              input logic a0, a1, stb);
    return '{c0: c0, s0: s0, c1: c1, s1: s1, ack: ack, g: g, a0: a0, a1: a1, stb: stb};
  endfunction

  function automatic logic any_out();
    return |{m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_cyc_o,
             s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, grant_o};
  endfunction

  task automatic idle_masters();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] exp_adr;
    logic [31:0] rdat [4];
    logic        exp_err, exp_stb;
    wr_t         w;

    tbl[0]  = mk(0,0,0,0,0, 2'b00, 0,0,0);
    tbl[1]  = mk(0,0,0,0,1, 2'b00, 0,0,0);
    tbl[2]  = mk(1,1,1,1,0, 2'b00, 0,0,0);
    tbl[3]  = mk(1,1,1,1,0, 2'b01, 0,0,1);
    tbl[4]  = mk(1,1,1,1,1, 2'b01, 1,0,1);
    tbl[5]  = mk(0,0,1,1,0, 2'b01, 0,0,0);
    tbl[6]  = mk(0,0,1,1,0, 2'b10, 0,0,1);
    tbl[7]  = mk(0,0,1,1,1, 2'b10, 0,1,1);
    tbl[8]  = mk(0,0,0,0,0, 2'b10, 0,0,0);
    tbl[9]  = mk(1,1,1,1,0, 2'b00, 0,0,0);
    tbl[10] = mk(1,1,1,1,0, 2'b01, 0,0,1);
    tbl[11] = mk(0,0,1,1,0, 2'b01, 0,0,0);
    tbl[12] = mk(0,0,1,1,0, 2'b10, 0,0,1);
    tbl[13] = mk(1,1,0,0,0, 2'b10, 0,0,0);
    tbl[14] = mk(1,1,0,0,0, 2'b01, 0,0,1);
    tbl[15] = mk(0,0,0,0,1, 2'b01, 1,0,0);
    tbl[16] = mk(0,0,0,0,0, 2'b00, 0,0,0);
    rdat[0] = 32'h11; rdat[1] = 32'h22; rdat[2] = 32'h33; rdat[3] = 32'h44;

    rst_n = 1'b0;
    idle_masters();
    m0_sel = 4'hF; m1_sel = 4'h3;
    m0_adr = A0; m1_adr = A1; m0_dat = 32'hAAAA_0000; m1_dat = 32'hBBBB_0000;
    s_ack_i = 1'b1; s_dat_i = 32'hFFFF_FFFF;
    #2;
    chk("reset_outputs", any_out(), 1'b0);
    @(negedge clk); @(negedge clk);
    s_ack_i = 1'b0; s_dat_i = '0;
    rst_n = 1'b1;
    #1;
    chk("post_reset_outputs", any_out(), 1'b0);

    // Arbitration sequence: round-robin, handover, stray ack, ack on release.
    for (int unsigned i = 0; i < NV; i++) begin
      @(negedge clk);
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1;
      s_ack_i = tbl[i].ack;
      s_dat_i = 32'hA5A5_0000 | i;
      #1;
      exp_adr = (tbl[i].g == 2'b01) ? A0 : (tbl[i].g == 2'b10) ? A1 : 32'h0;
      chk($sformatf("vec%0d grant", i), grant_o, tbl[i].g);
      chk($sformatf("vec%0d m0_ack", i), m0_ack_o, tbl[i].a0);
      chk($sformatf("vec%0d m1_ack", i), m1_ack_o, tbl[i].a1);
      chk($sformatf("vec%0d s_stb", i), s_stb_o, tbl[i].stb);
      chk($sformatf("vec%0d s_adr", i), s_adr_o, exp_adr);
      chk($sformatf("vec%0d m0_dat", i), m0_dat_o, tbl[i].g[0] ? s_dat_i : 32'h0);
      chk($sformatf("vec%0d m1_dat", i), m1_dat_o, tbl[i].g[1] ? s_dat_i : 32'h0);
    end

    // Single write from m0, slave acks two cycles after strobe.
    @(negedge clk);
    idle_masters(); s_ack_i = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1;
    m0_adr = 32'h3000_0004; m0_dat = 32'hDEAD_BEEF; m0_sel = 4'hF;
    wr_q.push_back('{adr: m0_adr, dat: m0_dat, sel: m0_sel, we: 1'b1});
    #1;
    chk("wr grant_latency", grant_o, 2'b00);
    chk("wr stb_latency", s_stb_o, 1'b0);
    @(negedge clk); #1;
    chk("wr grant", grant_o, 2'b01);
    chk("wr s_stb", s_stb_o, 1'b1);
    if (wr_q.size() > 0) begin
      w = wr_q.pop_front();
      chk("wr s_adr", s_adr_o, w.adr);
      chk("wr s_dat", s_dat_o, w.dat);
      chk("wr s_sel", s_sel_o, w.sel);
      chk("wr s_we", s_we_o, w.we);
    end else chk("wr queue", 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("wr ack_early", m0_ack_o, 1'b0);
    @(negedge clk); s_ack_i = 1'b1; #1;
    chk("wr m0_ack", m0_ack_o, 1'b1);
    chk("wr m1_ack", m1_ack_o, 1'b0);
    @(negedge clk); s_ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; #1;
    chk("wr ack_one_cycle", m0_ack_o, 1'b0);
    chk("wr grant_hold", grant_o, 2'b01);
    @(negedge clk); #1;
    chk("wr grant_release", grant_o, 2'b00);
    chk("wr s_cyc_release", s_cyc_o, 1'b0);

    // Burst of four reads by m0 while m1 waits.
    for (int unsigned b = 0; b < 4; b++) rd_q.push_back(rdat[b]);
    @(negedge clk);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h3000_0010; #1;
    chk("burst grant_latency", grant_o, 2'b00);
    @(negedge clk);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h3000_0020; #1;
    chk("burst grant", grant_o, 2'b01);
    for (int unsigned b = 0; b < 4; b++) begin
      @(negedge clk); s_ack_i = 1'b0; #1;
      chk($sformatf("burst%0d wait_grant", b), grant_o, 2'b01);
      chk($sformatf("burst%0d wait_m1_ack", b), m1_ack_o, 1'b0);
      @(negedge clk); s_ack_i = 1'b1; s_dat_i = rdat[b]; #1;
      chk($sformatf("burst%0d m0_ack", b), m0_ack_o, 1'b1);
      chk($sformatf("burst%0d m0_dat", b), m0_dat_o, rd_q.pop_front());
      chk($sformatf("burst%0d m1_ack", b), m1_ack_o, 1'b0);
      chk($sformatf("burst%0d m1_dat", b), m1_dat_o, 32'h0);
    end
    chk("burst queue_drained", rd_q.size(), 0);
    @(negedge clk); s_ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; #1;
    chk("burst release_grant", grant_o, 2'b01);
    @(negedge clk); #1;
    chk("burst m1_grant", grant_o, 2'b10);
    chk("burst m1_adr", s_adr_o, 32'h3000_0020);
    chk("burst m1_stb", s_stb_o, 1'b1);
    @(negedge clk); s_ack_i = 1'b1; s_dat_i = 32'h55; #1;
    chk("burst m1_ack", m1_ack_o, 1'b1);
    chk("burst m1_rdat", m1_dat_o, 32'h55);
    chk("burst m0_ack_off", m0_ack_o, 1'b0);
    @(negedge clk); s_ack_i = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    @(negedge clk); #1;
    chk("burst idle", grant_o, 2'b00);

    // Watchdog: m1 read with a silent slave.
    @(negedge clk); m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h3000_0040; #1;
    chk("wd grant_latency", grant_o, 2'b00);
    for (int unsigned j = 0; j < 10; j++) begin
      @(negedge clk); #1;
`ifdef WB_ARB_TIMEOUT_EN
      exp_err = (j == 8);
      exp_stb = (j != 8);
`else
      exp_err = 1'b0;
      exp_stb = 1'b1;
`endif
      chk($sformatf("wd%0d m1_err", j), m1_err_o, exp_err);
      chk($sformatf("wd%0d m0_err", j), m0_err_o, 1'b0);
      chk($sformatf("wd%0d s_stb", j), s_stb_o, exp_stb);
      chk($sformatf("wd%0d grant", j), grant_o, 2'b10);
    end
    @(negedge clk); m1_cyc = 1'b0; m1_stb = 1'b0;
    @(negedge clk); #1;
    chk("wd idle", grant_o, 2'b00);

    // Reset while m1 holds the grant with a pending strobe.
    @(negedge clk); m1_cyc = 1'b1; m1_stb = 1'b1;
    @(negedge clk); #1;
    chk("rst pre_grant", grant_o, 2'b10);
    chk("rst pre_stb", s_stb_o, 1'b1);
    s_dat_i = 32'hFFFF_FFFF; s_ack_i = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst async_outputs", any_out(), 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h3000_0050;
    #1;
    chk("rst late_ack_m1", m1_ack_o, 1'b0);
    chk("rst late_ack_m0", m0_ack_o, 1'b0);
    chk("rst grant_idle", grant_o, 2'b00);
    @(negedge clk); s_ack_i = 1'b0; #1;
    chk("rst m0_first", grant_o, 2'b01);
    @(negedge clk); idle_masters();
    @(negedge clk); #1;
    chk("rst idle", grant_o, 2'b00);

    // Stray ack while idle.
    @(negedge clk); s_ack_i = 1'b1; s_dat_i = 32'h1234_5678; #1;
    chk("stray m0_ack", m0_ack_o, 1'b0);
    chk("stray m1_ack", m1_ack_o, 1'b0);
    chk("stray m0_dat", m0_dat_o, 32'h0);
    @(negedge clk); s_ack_i = 1'b0; #1;
    chk("stray stays_idle", grant_o, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
